// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci series checker.
package fib_pkg;

  localparam int FIB_BITS_DEF  = 10;
  localparam int FIB_CNT_W_DEF = 8;

  // Canonical seeds of the series.
  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;

  typedef enum logic [2:0] {
    S_SEED0 = 3'd0,
    S_SEED1 = 3'd1,
    S_TRACK = 3'd2,
    S_OVF   = 3'd3,
    S_ERR   = 3'd4
  } fib_chk_state_t;

endpackage

// File: rtl/fib_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module fib_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Count accepted events, holding at all-ones.
  always_ff @(posedge clk) begin
    if (clr)      cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/fib_seq_checker.sv
// Self-checking sink for the Fibonacci generator: verifies f(n) = f(n-1) + f(n-2),
// counts accepted terms, and ends in a sticky overflow or mismatch state.
// Optional build macro FIB_CHK_ERRCAP_EN adds err_exp/err_got/err_idx capture ports.
module fib_seq_checker
  import fib_pkg::*;
#(
  parameter int FibBits    = FIB_BITS_DEF,
  parameter int CNT_W      = FIB_CNT_W_DEF,
  parameter int CHECK_SEED = 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [FibBits-1:0] f,
  output logic [CNT_W-1:0]   term_cnt,
  output logic               tracking,
  output logic               ovf,
  output logic               err
`ifdef FIB_CHK_ERRCAP_EN
  ,
  output logic [FibBits-1:0] err_exp,
  output logic [FibBits-1:0] err_got,
  output logic [CNT_W-1:0]   err_idx
`endif
);

  fib_chk_state_t     state, state_nx;
  logic [FibBits-1:0] a, b, a_nx, b_nx;
  logic [FibBits:0]   sum_p0;
  logic               inc;

  // One extra bit so the carry flags that the next term no longer fits.
  assign sum_p0 = {1'b0, a} + {1'b0, b};

  // Next-state, history and count-enable decision for the sampled term.
  always_comb begin
    state_nx = state;
    a_nx     = a;
    b_nx     = b;
    inc      = 1'b0;
    case (state)
      S_SEED0: begin
        if ((CHECK_SEED != 0) && (f != FibBits'(FIB_SEED0))) begin
          state_nx = S_ERR;
        end else begin
          a_nx     = f;
          inc      = 1'b1;
          state_nx = S_SEED1;
        end
      end
      S_SEED1: begin
        if ((CHECK_SEED != 0) && (f != FibBits'(FIB_SEED1))) begin
          state_nx = S_ERR;
        end else begin
          b_nx     = f;
          inc      = 1'b1;
          state_nx = S_TRACK;
        end
      end
      S_TRACK: begin
        if (sum_p0[FibBits]) begin
          state_nx = S_OVF;
        end else if (f == sum_p0[FibBits-1:0]) begin
          a_nx = b;
          b_nx = f;
          inc  = 1'b1;
        end else begin
          state_nx = S_ERR;
        end
      end
      S_OVF, S_ERR: ;
      // Unused encodings are treated as a fault rather than silently tracking.
      default: state_nx = S_ERR;
    endcase
  end

  // State and term history registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= S_SEED0;
      a     <= '0;
      b     <= '0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      b     <= b_nx;
    end
  end

  fib_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .clr (!nrst),
    .inc (inc),
    .cnt (term_cnt)
  );

  assign tracking = (state == S_SEED0) || (state == S_SEED1) || (state == S_TRACK);
  assign ovf      = (state == S_OVF);
  assign err      = (state == S_ERR);

`ifdef FIB_CHK_ERRCAP_EN
  logic [FibBits-1:0] exp_p0;

  // Value the checker wanted for the current sample.
  always_comb begin
    case (state)
      S_SEED0: exp_p0 = FibBits'(FIB_SEED0);
      S_SEED1: exp_p0 = FibBits'(FIB_SEED1);
      default: exp_p0 = sum_p0[FibBits-1:0];
    endcase
  end

  // Snapshot the failing term on the transition into the error state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_exp <= '0;
      err_got <= '0;
      err_idx <= '0;
    end else if ((state_nx == S_ERR) && (state != S_ERR)) begin
      err_exp <= exp_p0;
      err_got <= f;
      err_idx <= term_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fib_seq_checker.sv
// Bench for fib_seq_checker: three instances (default, unchecked seeds,
// narrow counter / wide word) driven in lockstep and compared to a reference model.
module tb_fib_seq_checker;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [9:0]  f_a = '0;
  logic [9:0]  f_b = '0;
  logic [15:0] f_c = '0;

  logic [7:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;
  logic        trk_a, trk_b, trk_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        err_a, err_b, err_c;
`ifdef FIB_CHK_ERRCAP_EN
  logic [9:0]  ee_a, eg_a, ee_b, eg_b;
  logic [15:0] ee_c, eg_c;
  logic [7:0]  ei_a, ei_b;
  logic [2:0]  ei_c;
`endif

  always #5 clk = ~clk;

  fib_seq_checker #(.FibBits(10), .CNT_W(8), .CHECK_SEED(1)) dut_a (
    .clk(clk), .nrst(nrst), .f(f_a), .term_cnt(cnt_a), .tracking(trk_a), .ovf(ovf_a), .err(err_a)
`ifdef FIB_CHK_ERRCAP_EN
    , .err_exp(ee_a), .err_got(eg_a), .err_idx(ei_a)
`endif
  );

  fib_seq_checker #(.FibBits(10), .CNT_W(8), .CHECK_SEED(0)) dut_b (
    .clk(clk), .nrst(nrst), .f(f_b), .term_cnt(cnt_b), .tracking(trk_b), .ovf(ovf_b), .err(err_b)
`ifdef FIB_CHK_ERRCAP_EN
    , .err_exp(ee_b), .err_got(eg_b), .err_idx(ei_b)
`endif
  );

  fib_seq_checker #(.FibBits(16), .CNT_W(3), .CHECK_SEED(1)) dut_c (
    .clk(clk), .nrst(nrst), .f(f_c), .term_cnt(cnt_c), .tracking(trk_c), .ovf(ovf_c), .err(err_c)
`ifdef FIB_CHK_ERRCAP_EN
    , .err_exp(ee_c), .err_got(eg_c), .err_idx(ei_c)
`endif
  );

  // Reference model: the list of accepted terms reduced to its last two values.
  typedef struct packed {
    int n;      // accepted terms, unsaturated
    int p1;     // last accepted term
    int p2;     // the one before
    bit err;
    bit ovf;
    int cexp;
    int cgot;
    int cidx;
  } mdl_t;

  mdl_t ma, mb, mc;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic int sat(input int n, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m = '0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t mi, input int fv, input int w, input bit cs, input int cw);
    mdl_t m;
    int   e;
    m = mi;
    if (m.err || m.ovf) return m;
    if (m.n < 2) begin
      // Required seeds happen to equal their index: 0 then 1.
      if (cs && fv != m.n) begin
        m.err = 1'b1; m.cexp = m.n; m.cgot = fv; m.cidx = sat(m.n, cw);
      end else begin
        m.p2 = m.p1; m.p1 = fv; m.n = m.n + 1;
      end
      return m;
    end
    e = m.p1 + m.p2;
    if (e >= (1 << w)) begin
      m.ovf = 1'b1;
    end else if (fv == e) begin
      m.p2 = m.p1; m.p1 = fv; m.n = m.n + 1;
    end else begin
      m.err = 1'b1; m.cexp = e; m.cgot = fv; m.cidx = sat(m.n, cw);
    end
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic cmp_one(input string p, input mdl_t m, input int cw,
                         input int cnt, input int trk, input int ov, input int er);
    chk({p, ".term_cnt"}, cnt, sat(m.n, cw));
    chk({p, ".tracking"}, trk, int'(!m.err && !m.ovf));
    chk({p, ".ovf"}, ov, int'(m.ovf));
    chk({p, ".err"}, er, int'(m.err));
  endtask

  task automatic cmp_all();
    cmp_one("a", ma, 8, int'(cnt_a), int'(trk_a), int'(ovf_a), int'(err_a));
    cmp_one("b", mb, 8, int'(cnt_b), int'(trk_b), int'(ovf_b), int'(err_b));
    cmp_one("c", mc, 3, int'(cnt_c), int'(trk_c), int'(ovf_c), int'(err_c));
`ifdef FIB_CHK_ERRCAP_EN
    chk("a.err_exp", int'(ee_a), ma.cexp); chk("a.err_got", int'(eg_a), ma.cgot); chk("a.err_idx", int'(ei_a), ma.cidx);
    chk("b.err_exp", int'(ee_b), mb.cexp); chk("b.err_got", int'(eg_b), mb.cgot); chk("b.err_idx", int'(ei_b), mb.cidx);
    chk("c.err_exp", int'(ee_c), mc.cexp); chk("c.err_got", int'(eg_c), mc.cgot); chk("c.err_idx", int'(ei_c), mc.cidx);
`endif
  endtask

  // One clock: drive at the falling edge, sample on the rising edge, compare at the next falling edge.
  task automatic cycle(input bit rn, input int fa, input int fb, input int fc);
    nrst = rn;
    f_a  = fa[9:0];
    f_b  = fb[9:0];
    f_c  = fc[15:0];
    @(posedge clk);
    if (!rn) begin
      ma = mreset(); mb = mreset(); mc = mreset();
    end else begin
      ma = mstep(ma, int'(f_a), 10, 1'b1, 8);
      mb = mstep(mb, int'(f_b), 10, 1'b0, 8);
      mc = mstep(mc, int'(f_c), 16, 1'b1, 3);
    end
    @(negedge clk);
    cmp_all();
  endtask

  function automatic int fib(input int k);
    int x, y, t;
    x = 0; y = 1;
    for (int i = 0; i < k; i++) begin
      t = x + y; x = y; y = t;
    end
    return x;
  endfunction

  typedef struct {
    bit rn;
    int fv;
    int cnt;
    bit trk;
    bit ov;
    bit er;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1, 2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1, 3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2, 4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4, 4, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5, 4, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2, 1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0};

    ma = mreset(); mb = mreset(); mc = mreset();
    @(negedge clk);

    // Table: forced streams on the default instance with fixed expectations.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rn, tbl[i].fv, tbl[i].fv, tbl[i].fv);
      chk($sformatf("tbl%0d.term_cnt", i), int'(cnt_a), tbl[i].cnt);
      chk($sformatf("tbl%0d.tracking", i), int'(trk_a), int'(tbl[i].trk));
      chk($sformatf("tbl%0d.ovf", i), int'(ovf_a), int'(tbl[i].ov));
      chk($sformatf("tbl%0d.err", i), int'(err_a), int'(tbl[i].er));
`ifdef FIB_CHK_ERRCAP_EN
      if (i == 5) begin
        chk("tbl5.err_exp", int'(ee_a), 3);
        chk("tbl5.err_got", int'(eg_a), 4);
        chk("tbl5.err_idx", int'(ei_a), 4);
      end
      if (i == 7) chk("tbl7.err_got_clr", int'(eg_a), 0);
`endif
    end

    // Unchecked seeds accept 2,3,5,8.
    cycle(1'b0, 0, 0, 0);
    cycle(1'b1, 0, 2, 0);
    cycle(1'b1, 1, 3, 1);
    cycle(1'b1, 1, 5, 1);
    cycle(1'b1, 2, 8, 2);
    chk("noseed.term_cnt", int'(cnt_b), 4);
    chk("noseed.err", int'(err_b), 0);

    // Full series through overflow on both word widths.
    cycle(1'b0, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      cycle(1'b1, fib(k), fib(k), fib(k));
      if (k == 19) begin
        chk("wide.sat_cnt", int'(cnt_c), 7);
        chk("wide.tracking", int'(trk_c), 1);
      end
    end
    chk("series.term_cnt", int'(cnt_a), 17);
    chk("series.ovf", int'(ovf_a), 1);
    chk("series.err", int'(err_a), 0);
    chk("series.tracking", int'(trk_a), 0);
    chk("wide.ovf", int'(ovf_c), 1);
    chk("wide.terms", mc.n, 25);

    // Reset mid-series after 5 terms, held 2 cycles.
    cycle(1'b0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(1'b1, fib(k), fib(k), fib(k));
    cycle(1'b0, 0, 0, 0);
    cycle(1'b0, 0, 0, 0);
    chk("midrst.term_cnt", int'(cnt_a), 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, fib(k), fib(k), fib(k));
      chk($sformatf("midrst.cnt%0d", k), int'(cnt_a), k + 1);
    end

    // Randomized: generator streams with occasional corrupted terms.
    for (int t = 0; t < 40; t++) begin
      int s0, s1;
      int ga[30], gb[30];
      s0 = int'($urandom_range(0, 20));
      s1 = int'($urandom_range(0, 20));
      ga[0] = 0; ga[1] = 1;
      gb[0] = s0; gb[1] = s1;
      for (int k = 2; k < 30; k++) begin
        ga[k] = ga[k-1] + ga[k-2];
        gb[k] = gb[k-1] + gb[k-2];
      end
      cycle(1'b0, 0, 0, 0);
      for (int k = 0; k < 30; k++) begin
        int va, vb, vc;
        va = ga[k]; vb = gb[k]; vc = ga[k];
        if ($urandom_range(0, 15) == 0) va = int'($urandom_range(0, 1023));
        if ($urandom_range(0, 15) == 0) vb = int'($urandom_range(0, 1023));
        if ($urandom_range(0, 15) == 0) vc = int'($urandom_range(0, 65535));
        cycle(1'b1, va, vb, vc);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
